// File: rtl/input_memory_node.sv
// Streaming read node: fetches imn_size_i bytes from imn_addr_i over OBI and
// forwards the words to the CGRA through a credit-limited read-data FIFO.
package input_memory_node_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module input_memory_node
  import input_memory_node_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  output obi_req_t    masters_req_o,
  input  obi_resp_t   masters_resp_i,
  input  logic [31:0] imn_addr_i,
  input  logic [15:0] imn_size_i,
  input  logic        exec_i,
  output logic        done_o,
  output logic [31:0] dout_o,
  output logic        dout_v_o,
  input  logic        dout_r_i
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_MREQ, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [15:0]   addr_offset_q;
  logic [AW:0]   outstanding_q;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]   usage;
  logic [AW+1:0] credit;
  logic          req, issue, push, pop, empty, last_issue;

  assign usage      = wr_ptr_q - rd_ptr_q;
  assign empty      = (usage == '0);
  // In-flight reads plus buffered words never exceed the FIFO, so a push always has room.
  assign credit     = {1'b0, outstanding_q} + {1'b0, usage};
  assign issue      = req & masters_resp_i.gnt;
  assign push       = masters_resp_i.rvalid & (outstanding_q != '0);
  assign pop        = ~empty & dout_r_i;
  assign last_issue = ({1'b0, addr_offset_q} + 17'd4) >= {1'b0, imn_size_i};

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q       <= S_IDLE;
      addr_offset_q <= '0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q <= state_d;
      if (issue) addr_offset_q <= addr_offset_q + 16'd4;
      if (issue && !push)      outstanding_q <= outstanding_q + 1'b1;
      else if (!issue && push) outstanding_q <= outstanding_q - 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= masters_resp_i.rdata;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (exec_i) state_d = (imn_size_i == '0) ? S_DONE : S_MREQ;
      S_MREQ:  if (issue && last_issue) state_d = S_DRAIN;
      S_DRAIN: if (outstanding_q == '0 && empty) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req    = (state_q == S_MREQ) && (credit < DEPTH_W);
    done_o = (state_q == S_DONE);
  end

  always_comb begin
    masters_req_o       = '0;
    masters_req_o.req   = req;
    masters_req_o.we    = 1'b0;
    masters_req_o.be    = 4'b1111;
    masters_req_o.addr  = imn_addr_i + {16'd0, addr_offset_q};
    masters_req_o.wdata = '0;
  end

  assign dout_o   = fifo_mem[rd_ptr_q[AW-1:0]];
  assign dout_v_o = ~empty;

endmodule

// File: tb/tb_input_memory_node.sv
// Scoreboard bench for input_memory_node: OBI memory responder, expected-word
// queue filled at stream start, monitor pops and compares on each handshake.
module tb_input_memory_node;
  import input_memory_node_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clr_i = 1'b0;
  logic        exec_i = 1'b0;
  logic        dout_r_i = 1'b0;
  logic [31:0] imn_addr_i = '0;
  logic [15:0] imn_size_i = '0;
  logic        done_o, dout_v_o;
  logic [31:0] dout_o;
  obi_req_t    masters_req_o;
  obi_resp_t   masters_resp_i = '0;

  always #5 clk_i = ~clk_i;

  input_memory_node #(.FIFO_DEPTH(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clr_i),
    .masters_req_o  (masters_req_o),
    .masters_resp_i (masters_resp_i),
    .imn_addr_i     (imn_addr_i),
    .imn_size_i     (imn_size_i),
    .exec_i         (exec_i),
    .done_o         (done_o),
    .dout_o         (dout_o),
    .dout_v_o       (dout_v_o),
    .dout_r_i       (dout_r_i)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  int gnt_mode = 0;
  int gnt_limit = 1000000;
  int grants = 0;
  int lat_min = 1, lat_max = 1;
  int cyc = 0;
  int last_due = 0;
  bit check_stable = 1'b0;
  logic [31:0] pend_addr [$];
  int pend_due [$];
  bit prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Memory responder: grants and in-order read responses, decided each negedge.
  always @(negedge clk_i) begin
    bit g;
    int d;
    cyc++;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      masters_resp_i.rvalid = 1'b1;
      masters_resp_i.rdata  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      masters_resp_i.rvalid = 1'b0;
      masters_resp_i.rdata  = 32'hDEAD_BEEF;
    end
    if (check_stable && prev_wait) begin
      tests++;
      if (!(masters_req_o.req && masters_req_o.addr == prev_addr)) begin
        fails++;
        $display("FAIL req_stable: req=%0b addr=%h, required req=1 addr=%h",
                 masters_req_o.req, masters_req_o.addr, prev_addr);
      end
    end
    case (gnt_mode)
      0:       g = 1'b1;
      1:       g = ($urandom_range(0, 99) < 30);
      default: g = 1'b0;
    endcase
    if (grants >= gnt_limit) g = 1'b0;
    masters_resp_i.gnt = g;
    if (masters_req_o.req && g) begin
      grants++;
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_addr.push_back(masters_req_o.addr);
      pend_due.push_back(d);
    end
    prev_wait = masters_req_o.req && !g;
    prev_addr = masters_req_o.addr;
  end

  // Monitor: every accepted output word must match the head of the scoreboard.
  always @(negedge clk_i) begin
    logic [31:0] e;
    #2;
    if (!rst_i && !clr_i && dout_v_o && dout_r_i) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL dout_unexpected: got %h, required no output", dout_o);
      end else begin
        e = exp_q.pop_front();
        if (dout_o !== e) begin
          fails++;
          $display("FAIL dout_data: got %h, required %h", dout_o, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req_v);
    end
  endtask

  task automatic do_clr();
    dout_r_i = 1'b0;
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    exp_q.delete();
    grants = 0;
  endtask

  task automatic start_stream(input logic [31:0] addr, input logic [15:0] size);
    int n;
    n = (int'(size) + 3) / 4;
    for (int i = 0; i < n; i++) exp_q.push_back(mem_word(addr + 32'(4 * i)));
    imn_addr_i = addr;
    imn_size_i = size;
    exec_i = 1'b1;
    tick(1);
    exec_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit rand_ready);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      if (rand_ready) dout_r_i = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    check({name, "_done"}, {31'd0, done_o}, 32'd1);
    check({name, "_all_words"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    tick(3);
    rst_i = 1'b0;
    tick(1);
    check("rst_req", {31'd0, masters_req_o.req}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_dout_v", {31'd0, dout_v_o}, 32'd0);

    // 16-byte stream, grant always, latency 1, ready always
    gnt_mode = 0; lat_min = 1; lat_max = 1;
    dout_r_i = 1'b1;
    start_stream(32'h0000_1000, 16'd16);
    wait_done("s16", 200, 1'b0);
    check("s16_grants", grants, 32'd4);

    // Zero-length stream completes immediately without requests
    do_clr();
    dout_r_i = 1'b1;
    start_stream(32'h0000_1800, 16'd0);
    check("s0_done_next", {31'd0, done_o}, 32'd1);
    tick(3);
    check("s0_grants", grants, 32'd0);
    check("s0_req", {31'd0, masters_req_o.req}, 32'd0);

    // Backpressure: 64 bytes with ready low stalls after 8 credits
    do_clr();
    start_stream(32'h0000_2000, 16'd64);
    tick(40);
    check("bp_grants_stalled", grants, 32'd8);
    check("bp_req_low", {31'd0, masters_req_o.req}, 32'd0);
    check("bp_dout_v", {31'd0, dout_v_o}, 32'd1);
    check("bp_done_low", {31'd0, done_o}, 32'd0);
    dout_r_i = 1'b1;
    wait_done("bp", 400, 1'b0);
    check("bp_grants_total", grants, 32'd16);

    // Non-multiple-of-4 size rounds up to whole words
    do_clr();
    dout_r_i = 1'b1;
    start_stream(32'h0000_3000, 16'd6);
    wait_done("s6", 200, 1'b0);
    check("s6_grants", grants, 32'd2);

    // Random grant, latency and ready
    do_clr();
    gnt_mode = 1; lat_min = 1; lat_max = 4;
    check_stable = 1'b1;
    start_stream(32'h0000_4000, 16'd128);
    wait_done("rnd", 4000, 1'b1);
    check("rnd_grants", grants, 32'd32);
    check_stable = 1'b0;

    // Clear mid-stream with reads in flight, then restart
    do_clr();
    gnt_mode = 0; gnt_limit = 3; lat_min = 3; lat_max = 3;
    start_stream(32'h0000_5000, 16'd64);
    n = 0;
    while (!(grants == 3 && pend_due.size() == 2) && n < 50) begin
      tick(1);
      #1;
      n++;
    end
    check("clr_setup", {31'd0, (grants == 3 && pend_due.size() == 2)}, 32'd1);
    tick(1);
    do_clr();
    dout_r_i = 1'b1;
    tick(6);
    check("clr_late_done", pend_due.size(), 32'd0);
    check("clr_dout_v", {31'd0, dout_v_o}, 32'd0);
    check("clr_req", {31'd0, masters_req_o.req}, 32'd0);
    check("clr_done", {31'd0, done_o}, 32'd0);
    gnt_limit = 1000000; lat_min = 1; lat_max = 1;
    start_stream(32'h0000_5000, 16'd8);
    wait_done("clr_restart", 200, 1'b0);
    check("clr_restart_grants", grants, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_memory_node.md
INPUT_MEMORY_NODE -- requirements
Module: input_memory_node

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: read-data buffer depth in 32-bit words (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port clr_i  input  1  synchronous clear, active-high.
REQ-005 SHALL have port masters_req_o  output  obi_req_t  OBI master request (req, we, be, addr, wdata).
REQ-006 SHALL have port masters_resp_i  input  obi_resp_t  OBI response (gnt, rvalid, rdata).
REQ-007 SHALL have port imn_addr_i  input  32  base byte address of the stream.
REQ-008 SHALL have port imn_size_i  input  16  stream length in bytes.
REQ-009 SHALL have port exec_i  input  1  start strobe/level.
REQ-010 SHALL have port done_o  output  1  stream complete.
REQ-011 SHALL have port dout_o  output  32  data to the CGRA.
REQ-012 SHALL have port dout_v_o  output  1  dout_o valid.
REQ-013 SHALL have port dout_r_i  input  1  CGRA ready.

Function
REQ-014 SHALL drive we=0, be=4'b1111, wdata=0 constantly; addr = imn_addr_i + zero-extended 16-bit addr_offset.
REQ-015 SHALL implement states S_IDLE, S_MREQ, S_DRAIN, S_DONE.
REQ-016 S_IDLE: on exec_i, go to S_DONE if imn_size_i==0, else S_MREQ; otherwise stay.
REQ-017 S_MREQ: req = (outstanding + fifo_usage) < FIFO_DEPTH; issue = req & gnt.
REQ-018 On issue, addr_offset SHALL increment by 4 (16-bit wrap) and outstanding SHALL increment.
REQ-019 S_MREQ -> S_DRAIN on the issue where addr_offset+4 >= imn_size_i (non-multiple-of-4 sizes round up to whole words).
REQ-020 On rvalid, rdata SHALL be pushed into the FIFO the same cycle and outstanding decremented; simultaneous issue and rvalid leave outstanding unchanged.
REQ-021 Responses SHALL be in order; credit rule (REQ-017) guarantees the FIFO never overflows; rvalid with outstanding==0 SHALL be ignored.
REQ-022 dout_o = FIFO head, dout_v_o = !empty; pop on dout_v_o & dout_r_i; push and pop in the same cycle SHALL both take effect, including when full.
REQ-023 S_DRAIN: req=0; -> S_DONE when outstanding==0 and FIFO empty.
REQ-024 S_DONE: done_o=1, req=0; stays until rst_i or clr_i; exec_i ignored.
REQ-025 req SHALL be asserted in no state other than S_MREQ; once asserted, req and addr SHALL stay stable until gnt.
REQ-026 First read data SHALL reach dout_o no earlier than one cycle after its rvalid (FIFO registered).
REQ-027 outstanding counter SHALL be $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-028 On rst_i or clr_i: state=S_IDLE, addr_offset=0, outstanding=0, FIFO flushed; clr_i has equal priority to rst_i.
REQ-029 Post-reset outputs: req=0, done_o=0, dout_v_o=0, dout_o don't-care.
REQ-030 Mid-stream clr_i SHALL abandon in-flight reads; rvalids arriving afterwards SHALL be dropped (outstanding==0).

Verification
REQ-031 size=16, addr=0x1000, gnt always 1, rvalid 1 cycle later, dout_r_i=1 -> reads 0x1000..0x100C, 4 words out in order, done_o one cycle after the last pop completes the drain.
REQ-032 size=0, exec_i pulse -> S_DONE next cycle, done_o=1, no req ever.
REQ-033 size=64, dout_r_i=0 -> exactly 8 grants then req=0; release ready -> remaining 8 reads resume, all 16 words delivered in order.
REQ-034 size=6 -> exactly 2 reads (offset 0, 4), 2 words delivered, done_o=1.
REQ-035 gnt random 30%, rvalid latency random 1-4, dout_r_i random -> output sequence equals memory contents, no overflow, req stable while waiting for gnt.
REQ-036 clr_i asserted after 3 grants with 2 rvalids pending -> S_IDLE, FIFO empty, late rvalids dropped, new exec_i restarts at offset 0.
